uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin transmit scheduler that shares the single `rs232_top` transmitter between `N_REQ` byte producers. It accepts one byte per valid/ready handshake and issues it to the UART as a one-cycle `tx_en` pulse with stable `tx_dat`. It then waits for `tx_over` before serving the next byte. Packet locking keeps multi-byte messages from interleaving, and a watchdog recovers from a UART that never reports completion.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 8192: cycles allowed between `o_tx_en` and `i_tx_over` before abort. This covers 10 bits × 434 clk at 115200 baud / 50 MHz.
- `ID_W`, $clog2(N_REQ): owner index width.
- `clk_ref` input 1: single clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_req_vld` input N_REQ: per-requester byte valid.
- `i_req_dat` input N_REQ*8: byte r is on bits [8r+7:8r].
- `i_req_last` input N_REQ: the byte offered by r ends its packet.
- `o_req_rdy` output N_REQ: one-hot. A byte transfers on a clock edge where vld[r] & rdy[r].
- `o_tx_dat` output 8: byte to `rs232_top.i_tx_dat`.
- `o_tx_en` output 1: one-cycle start pulse to `rs232_top.i_tx_en`.
- `i_tx_over` input 1: one-cycle done pulse from `rs232_top.o_tx_over`.
- `o_busy` output 1: high whenever state ≠ IDLE or a lock is held.
- `o_owner` output ID_W: index of the last granted requester.
- `o_timeout` output 1: one-cycle pulse when the watchdog aborts.

## Operation
- **States:**
  - IDLE: the only state where `o_req_rdy` may be non-zero.
  - SEND: drives `o_tx_en`=1 for exactly one cycle, then goes to WAIT unconditionally.
  - WAIT: the watchdog runs.
- **IDLE, unlocked:**
  - Grant the first set `i_req_vld` bit, searching from `ptr` upward with wrap.
  - `o_req_rdy[g]` is combinational from vld, state and ptr.
  - On the handshake edge: latch the byte into `o_tx_dat`, latch `last` into `cur_last`, set `o_owner`=g, go to SEND.
- **IDLE, locked** (a packet is in progress): only `i_req_vld[o_owner]` is eligible. Other requesters stall even if the owner's vld is low.
- **WAIT:**
  - On `i_tx_over`, go to IDLE.
  - If `cur_last`=1: clear the lock and set `ptr`=(o_owner+1) mod N_REQ.
  - Otherwise set the lock.
- **Watchdog:**
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When count = TIMEOUT-1 with no `i_tx_over`: pulse `o_timeout`, go to IDLE, clear the lock, advance `ptr` as for a last byte.
- **Simultaneous events:**
  - `i_tx_over` in the same cycle as the watchdog terminal count counts as success: no `o_timeout`.
  - `i_tx_over` outside WAIT is ignored.
  - Requester valid changes outside IDLE are ignored.
- **`o_tx_dat`:** holds its value from SEND until the next handshake.
- **`ptr` update:** only at packet end or timeout. It is never changed mid-packet.

## Timing
- **Reset values:** state=IDLE, `o_req_rdy`=0 (IDLE with no vld), `o_tx_dat`=8'h00, `o_tx_en`=0, `o_owner`=0, `o_timeout`=0, `o_busy`=0, ptr=0, lock=0, watchdog=0.
- **Reset mid-operation:** asserting `rst_n` low in any state returns all of the above immediately. A byte already started in `rs232_top` is abandoned.
- **Latency:** handshake at edge t → `o_tx_en`=1 during cycle t+1 → WAIT from t+2.
- **Back-to-back bytes:** `i_tx_over` at cycle k → IDLE at k+1, where rdy may be asserted → `o_tx_en` at k+2. This gives 2 cycles of gap beyond the UART frame.
- **Watchdog:** `o_timeout` fires TIMEOUT cycles after entering WAIT.
- **Counter width:** $clog2(TIMEOUT). It saturates at TIMEOUT-1 and never wraps.

## Structure
- **Package `uart_sched_pkg`:**
  - State encoding: IDLE=2'd0, SEND=2'd1, WAIT=2'd2. Code 2'd3 decodes to IDLE.
  - Byte width constant 8.
  - Default TIMEOUT.
- **Sub-module `rr_pick`:** combinational round-robin priority picker. Inputs are a request vector and a start pointer; outputs are a one-hot grant, its index, and an any flag. It is instantiated once.

## Test plan
- **Single byte:** r2 offers 8'hA5 with last=1 → rdy[2] in the same cycle; next cycle `o_tx_en`=1 with `o_tx_dat`=A5. `i_tx_over` 4340 cycles later → IDLE, ptr=3.
- **Fair arbitration:** all four vld held high with last=1 → grant order 0,1,2,3,0. Each grant follows the previous `i_tx_over` by 1 cycle.
- **Packet lock:** r1 sends 3 bytes 11,22,33 (last on 33) while r0 and r3 keep vld high → the UART sees 11,22,33 contiguously, then r3 is granted.
- **Watchdog:** `i_tx_over` is never returned with TIMEOUT=16 → `o_timeout` pulses 16 cycles after WAIT entry, state=IDLE, lock cleared. `i_tx_over` on the terminal cycle instead → no timeout.
- **Async reset:** pulse `rst_n` low during WAIT mid-packet → all outputs return to reset values without waiting for a clock. A fresh r0 byte afterwards is served normally.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Contents: FSM state encoding, byte width, default watchdog limit.
// No logic; imported by uart_tx_sched and rr_pick.
package uart_sched_pkg;

    localparam int BYTE_W      = 8;
    localparam int TIMEOUT_DEF = 8192;   // 10 bits x 434 clk (115200 baud @ 50 MHz) with margin

    // Code 2'd3 is unused and decodes to IDLE in the scheduler FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or after ptr, with wrap.
// Latency: purely combinational, zero cycles.
// Ports: req (request vector), ptr (start index) -> gnt (one-hot), idx, any.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int  k;
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = ID_W'(k);
            end
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// Latency: handshake edge t -> o_tx_en during t+1 -> waits for i_tx_over from t+2.
// Backpressure: o_req_rdy only in IDLE; a held packet lock stalls all other requesters.
// Ports: clk_ref/rst_n; i_req_vld/i_req_dat/i_req_last/o_req_rdy requester side;
//        o_tx_dat/o_tx_en/i_tx_over UART side; o_busy/o_owner/o_timeout status.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                    clk_ref,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        i_req_vld,
    input  logic [N_REQ*BYTE_W-1:0] i_req_dat,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_rdy,
    output logic [BYTE_W-1:0]       o_tx_dat,
    output logic                    o_tx_en,
    input  logic                    i_tx_over,
    output logic                    o_busy,
    output logic [ID_W-1:0]         o_owner,
    output logic                    o_timeout
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

    state_e            state, nxt;
    logic [ID_W-1:0]   ptr;
    logic              lock;
    logic              cur_last;
    logic [CNT_W-1:0]  wd_cnt;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;
    logic [BYTE_W-1:0] sel_dat;
    logic              sel_last;
    logic [ID_W-1:0]   ptr_adv;

    logic              is_idle;
    logic              hs;
    logic              tx_ok;
    logic              wd_fire;

    // While a packet is in flight only the owner may be picked, even if its
    // vld is low; everyone else waits for the packet to end.
    assign elig = lock ? (i_req_vld & (N_REQ'(1) << o_owner)) : i_req_vld;

    rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // One-hot byte / last mux driven by the grant.
    always_comb begin
        sel_dat  = '0;
        sel_last = 1'b0;
        for (int r = 0; r < N_REQ; r++) begin
            if (pick_gnt[r]) begin
                sel_dat  = sel_dat | i_req_dat[r*BYTE_W +: BYTE_W];
                sel_last = sel_last | i_req_last[r];
            end
        end
    end

    assign ptr_adv = (o_owner == ID_W'(N_REQ - 1)) ? '0 : o_owner + 1'b1;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt       = state;
        is_idle   = 1'b0;
        hs        = 1'b0;
        tx_ok     = 1'b0;
        wd_fire   = 1'b0;
        o_tx_en   = 1'b0;
        o_req_rdy = '0;
        case (state)
            ST_SEND: begin
                o_tx_en = 1'b1;
                nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion wins over the terminal count in the same cycle.
                if (i_tx_over) begin
                    tx_ok = 1'b1;
                    nxt   = ST_IDLE;
                end else if (wd_cnt == CNT_TERM) begin
                    wd_fire = 1'b1;
                    nxt     = ST_IDLE;
                end
            end
            default: begin
                // IDLE, and the unused encoding which behaves as IDLE.
                is_idle   = 1'b1;
                o_req_rdy = pick_gnt;
                nxt       = ST_IDLE;
                if (pick_any) begin
                    hs  = 1'b1;
                    nxt = ST_SEND;
                end
            end
        endcase
        o_busy = !is_idle || lock;
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_dat  <= '0;
            cur_last  <= 1'b0;
            o_owner   <= '0;
            ptr       <= '0;
            lock      <= 1'b0;
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= wd_fire;

            if (hs) begin
                o_tx_dat <= sel_dat;
                cur_last <= sel_last;
                o_owner  <= pick_idx;
            end

            // ptr moves only when a packet ends, normally or by abort.
            if (tx_ok) begin
                if (cur_last) begin
                    lock <= 1'b0;
                    ptr  <= ptr_adv;
                end else begin
                    lock <= 1'b1;
                end
            end
            if (wd_fire) begin
                lock <= 1'b0;
                ptr  <= ptr_adv;
            end

            // Cleared while in SEND so WAIT starts at zero; saturates at the terminal count.
            if (o_tx_en) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT && wd_cnt != CNT_TERM) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: vector table for arbitration and locking,
// hand sequences for watchdog abort, terminal-cycle completion and async reset.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_vld;
    logic [31:0] req_dat;
    logic [3:0]  req_last;
    logic [3:0]  req_rdy;
    logic [7:0]  tx_dat;
    logic        tx_en;
    logic        tx_over;
    logic        busy;
    logic [1:0]  owner;
    logic        tmo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ   (4),
        .TIMEOUT (16)
    ) dut (
        .clk_ref    (clk),
        .rst_n      (rst_n),
        .i_req_vld  (req_vld),
        .i_req_dat  (req_dat),
        .i_req_last (req_last),
        .o_req_rdy  (req_rdy),
        .o_tx_dat   (tx_dat),
        .o_tx_en    (tx_en),
        .i_tx_over  (tx_over),
        .o_busy     (busy),
        .o_owner    (owner),
        .o_timeout  (tmo)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  last;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_owner;
        logic [7:0]  exp_dat;
        logic        exp_busy;   // o_busy once back in IDLE (lock held)
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE. On a grant, returns at the negedge of WAIT entry.
    task automatic start_byte(input logic [3:0] vld, input logic [31:0] dat, input logic [3:0] last,
                              input logic [3:0] rdy_exp, input logic [1:0] own_exp,
                              input logic [7:0] dat_exp, input logic busy_exp, input string tag);
        req_vld  = vld;
        req_dat  = dat;
        req_last = last;
        #1;
        check({tag, " rdy"}, 32'(req_rdy), 32'(rdy_exp));
        if (rdy_exp != 4'b0000) begin
            @(negedge clk);
            check({tag, " tx_en"},    32'(tx_en),   32'd1);
            check({tag, " tx_dat"},   32'(tx_dat),  32'(dat_exp));
            check({tag, " owner"},    32'(owner),   32'(own_exp));
            check({tag, " rdy send"}, 32'(req_rdy), 32'd0);
            req_vld = 4'b0000;
            @(negedge clk);
            check({tag, " tx_en wait"},  32'(tx_en),  32'd0);
            check({tag, " tx_dat hold"}, 32'(tx_dat), 32'(dat_exp));
        end else begin
            check({tag, " busy stall"}, 32'(busy), 32'(busy_exp));
            @(negedge clk);
        end
    endtask

    task automatic finish_byte(input int dly, input logic busy_exp, input string tag);
        repeat (dly) @(negedge clk);
        tx_over = 1'b1;
        @(negedge clk);
        tx_over = 1'b0;
        check({tag, " busy idle"}, 32'(busy), 32'(busy_exp));
        check({tag, " no tmo"},    32'(tmo),  32'd0);
    endtask

    initial begin
        logic early;
        rst_n    = 1'b0;
        req_vld  = '0;
        req_dat  = '0;
        req_last = '0;
        tx_over  = 1'b0;

        //                vld    dat            last   rdy     own  dat   busy
        vecs[0]  = '{4'hF,  32'hA3A2A1A0, 4'hF,  4'b0001, 2'd0, 8'hA0, 1'b0};
        vecs[1]  = '{4'hF,  32'hA3A2A1A0, 4'hF,  4'b0010, 2'd1, 8'hA1, 1'b0};
        vecs[2]  = '{4'hF,  32'hA3A2A1A0, 4'hF,  4'b0100, 2'd2, 8'hA2, 1'b0};
        vecs[3]  = '{4'hF,  32'hA3A2A1A0, 4'hF,  4'b1000, 2'd3, 8'hA3, 1'b0};
        vecs[4]  = '{4'hF,  32'hA3A2A1A0, 4'hF,  4'b0001, 2'd0, 8'hA0, 1'b0};
        vecs[5]  = '{4'hB,  32'hB30011B0, 4'h9,  4'b0010, 2'd1, 8'h11, 1'b1};
        vecs[6]  = '{4'h9,  32'hB30000B0, 4'h9,  4'b0000, 2'd1, 8'h11, 1'b1};
        vecs[7]  = '{4'hB,  32'hB30022B0, 4'h9,  4'b0010, 2'd1, 8'h22, 1'b1};
        vecs[8]  = '{4'hB,  32'hB30033B0, 4'hB,  4'b0010, 2'd1, 8'h33, 1'b0};
        vecs[9]  = '{4'hB,  32'hB30044B0, 4'h9,  4'b1000, 2'd3, 8'hB3, 1'b0};
        vecs[10] = '{4'h4,  32'h00A50000, 4'h4,  4'b0100, 2'd2, 8'hA5, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst rdy",    32'(req_rdy), 32'd0);
        check("rst tx_dat", 32'(tx_dat),  32'd0);
        check("rst tx_en",  32'(tx_en),   32'd0);
        check("rst owner",  32'(owner),   32'd0);
        check("rst tmo",    32'(tmo),     32'd0);
        check("rst busy",   32'(busy),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // i_tx_over outside WAIT has no effect
        tx_over = 1'b1;
        @(negedge clk);
        tx_over = 1'b0;
        check("stray over busy",  32'(busy),  32'd0);
        check("stray over tx_en", 32'(tx_en), 32'd0);

        // Fair rotation, packet lock with a stalled owner, single byte
        for (int i = 0; i < 11; i++) begin
            start_byte(vecs[i].vld, vecs[i].dat, vecs[i].last, vecs[i].exp_rdy,
                       vecs[i].exp_owner, vecs[i].exp_dat, vecs[i].exp_busy,
                       $sformatf("vec%0d", i));
            if (vecs[i].exp_rdy != 4'b0000)
                finish_byte(3, vecs[i].exp_busy, $sformatf("vec%0d", i));
        end

        // Watchdog abort mid-packet: ptr=3, only r0 offers a non-last byte
        start_byte(4'b0001, 32'h000000C0, 4'b0000, 4'b0001, 2'd0, 8'hC0, 1'b0, "wd");
        early = 1'b0;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            if (tmo || !busy) early = 1'b1;
        end
        check("wd early", 32'(early), 32'd0);
        @(negedge clk);
        check("wd tmo pulse", 32'(tmo),   32'd1);
        check("wd busy",      32'(busy),  32'd0);
        check("wd tx_en",     32'(tx_en), 32'd0);
        @(negedge clk);
        check("wd tmo end",   32'(tmo),   32'd0);

        // Completion on the terminal count cycle: ptr=1 after the abort
        start_byte(4'b0010, 32'h0000D100, 4'b0010, 4'b0010, 2'd1, 8'hD1, 1'b0, "term");
        repeat (15) @(negedge clk);
        tx_over = 1'b1;
        @(negedge clk);
        tx_over = 1'b0;
        check("term tmo",  32'(tmo),  32'd0);
        check("term busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("term tmo late", 32'(tmo), 32'd0);

        // Async reset during WAIT of a locked packet from r3 (ptr=2)
        start_byte(4'b1000, 32'h5A000000, 4'b0000, 4'b1000, 2'd3, 8'h5A, 1'b0, "pre1");
        finish_byte(2, 1'b1, "pre1");
        start_byte(4'b1000, 32'h5B000000, 4'b0000, 4'b1000, 2'd3, 8'h5B, 1'b1, "pre2");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst tx_dat", 32'(tx_dat),  32'd0);
        check("arst tx_en",  32'(tx_en),   32'd0);
        check("arst owner",  32'(owner),   32'd0);
        check("arst tmo",    32'(tmo),     32'd0);
        check("arst busy",   32'(busy),    32'd0);
        check("arst rdy",    32'(req_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_byte(4'b0001, 32'h00000077, 4'b0001, 4'b0001, 2'd0, 8'h77, 1'b0, "post");
        finish_byte(3, 1'b0, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
